// File: rtl/spi_arb_pkg.sv
// Shared definitions for the spi_master client arbiter: FSM state encoding
// and the default spi_master register addresses.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_IDLE,
    WR_CFG,
    WR_DIV,
    WR_DATA,
    DONE
  } arb_state_t;

  localparam int DEF_CFG_ADDR  = 0;
  localparam int DEF_DIV_ADDR  = 1;
  localparam int DEF_DATA_ADDR = 2;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Rotating-priority pick: first requester at or after ptr, wrapping around.
module spi_rr_arbiter #(
  parameter  int NUM_CLIENTS = 4,
  localparam int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [ID_W-1:0]        ptr,
  output logic                   valid,
  output logic [ID_W-1:0]        idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_CLIENTS]) begin
        valid = 1'b1;
        idx   = ID_W'((int'(ptr) + k) % NUM_CLIENTS);
      end
    end
  end

endmodule

// File: rtl/spi_client_arbiter.sv
// Round-robin sharing of one spi_master register port among byte senders.
// Each transaction programs cfg and divider, then pushes the client's byte.
// Reprogramming waits for spi_idle so a byte still shifting is never retimed.
// Optional build macro SPI_ARB_CFG_CACHE_EN: remember the last cfg/div written
// and skip writes (and the idle wait) when the winner's values already match.
//
// state     | meaning
// IDLE      | no transaction, waiting for any cli_req
// GRANT     | winner chosen, its cfg/div/data latched this cycle
// WAIT_IDLE | reprogram pending, waiting for master idle
// WR_CFG    | writing cfg register
// WR_DIV    | writing divider register
// WR_DATA   | pushing the byte into the master FIFO
// DONE      | cli_ack pulse, pointer advanced
module spi_client_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8,
  parameter  int NUM_CLIENTS = 4,
  parameter  int CFG_ADDR    = DEF_CFG_ADDR,
  parameter  int DIV_ADDR    = DEF_DIV_ADDR,
  parameter  int DATA_ADDR   = DEF_DATA_ADDR,
  localparam int ID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            cli_req,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_cfg,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_div,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_data,
  output logic [NUM_CLIENTS-1:0]            cli_ack,
  output logic                              spi_req,
  output logic [DATA_WIDTH-1:0]             spi_address,
  output logic [DATA_WIDTH-1:0]             spi_data,
  input  logic                              spi_ack,
  input  logic                              spi_idle,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              busy
);

  localparam logic [DATA_WIDTH-1:0] A_CFG  = DATA_WIDTH'(CFG_ADDR);
  localparam logic [DATA_WIDTH-1:0] A_DIV  = DATA_WIDTH'(DIV_ADDR);
  localparam logic [DATA_WIDTH-1:0] A_DATA = DATA_WIDTH'(DATA_ADDR);

  arb_state_t            state;
  logic [ID_W-1:0]       ptr;
  logic                  pick_valid;
  logic [ID_W-1:0]       pick_idx;
  logic [DATA_WIDTH-1:0] sel_cfg, sel_div, sel_data;
  logic [DATA_WIDTH-1:0] lat_cfg, lat_div, lat_data;
  logic                  need_cfg, need_div;
  logic                  skip_cfg, skip_div;

  spi_rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
    .req   (cli_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_cfg  = cli_cfg [grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_div  = cli_div [grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_data = cli_data[grant_id*DATA_WIDTH +: DATA_WIDTH];

`ifdef SPI_ARB_CFG_CACHE_EN
  logic [DATA_WIDTH-1:0] last_cfg, last_div;
  logic                  cache_valid;

  // An invalid cache forces both writes, so cfg is always current by the
  // time the div write completes and validates the cache.
  assign skip_cfg = cache_valid && (last_cfg == sel_cfg);
  assign skip_div = cache_valid && (last_div == sel_div);

  // Track what the master was last programmed with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cfg    <= '0;
      last_div    <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (state == WR_CFG && spi_ack) last_cfg <= lat_cfg;
      if (state == WR_DIV && spi_ack) begin
        last_div    <= lat_div;
        cache_valid <= 1'b1;
      end
    end
  end
`else
  assign skip_cfg = 1'b0;
  assign skip_div = 1'b0;
`endif

  // Transaction sequencer; outputs are registered and loaded on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      spi_req     <= 1'b0;
      spi_address <= '0;
      spi_data    <= '0;
      cli_ack     <= '0;
      lat_cfg     <= '0;
      lat_div     <= '0;
      lat_data    <= '0;
      need_cfg    <= 1'b1;
      need_div    <= 1'b1;
    end else begin
      cli_ack <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          lat_cfg  <= sel_cfg;
          lat_div  <= sel_div;
          lat_data <= sel_data;
          need_cfg <= !skip_cfg;
          need_div <= !skip_div;
          if (skip_cfg && skip_div) begin
            spi_req     <= 1'b1;
            spi_address <= A_DATA;
            spi_data    <= sel_data;
            state       <= WR_DATA;
          end else begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (spi_idle) begin
            spi_req <= 1'b1;
            if (need_cfg) begin
              spi_address <= A_CFG;
              spi_data    <= lat_cfg;
              state       <= WR_CFG;
            end else begin
              spi_address <= A_DIV;
              spi_data    <= lat_div;
              state       <= WR_DIV;
            end
          end
        end
        WR_CFG: begin
          if (spi_ack) begin
            if (need_div) begin
              spi_address <= A_DIV;
              spi_data    <= lat_div;
              state       <= WR_DIV;
            end else begin
              spi_address <= A_DATA;
              spi_data    <= lat_data;
              state       <= WR_DATA;
            end
          end
        end
        WR_DIV: begin
          if (spi_ack) begin
            spi_address <= A_DATA;
            spi_data    <= lat_data;
            state       <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (spi_ack) begin
            spi_req <= 1'b0;
            busy    <= 1'b0;
            cli_ack <= NUM_CLIENTS'(1) << grant_id;
            ptr     <= (grant_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_client_arbiter.sv
// Bench for spi_client_arbiter: a small spi_master responder plus a
// behavioural model of round-robin order and expected register writes.
`timescale 1ns/1ps
module tb_spi_client_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam logic [7:0] A_CFG  = 8'd0;
  localparam logic [7:0] A_DIV  = 8'd1;
  localparam logic [7:0] A_DATA = 8'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  cli_req = '0;
  logic [N*DW-1:0] cli_cfg = '0, cli_div = '0, cli_data = '0;
  logic [N-1:0]  cli_ack;
  logic          spi_req;
  logic [DW-1:0] spi_address, spi_data;
  logic          spi_ack = 1'b0;
  logic          spi_idle = 1'b1;
  logic [1:0]    grant_id;
  logic          busy;

  always #5 clk = ~clk;

  spi_client_arbiter #(.DATA_WIDTH(DW), .NUM_CLIENTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_cfg(cli_cfg),
    .cli_div(cli_div), .cli_data(cli_data), .cli_ack(cli_ack),
    .spi_req(spi_req), .spi_address(spi_address), .spi_data(spi_data),
    .spi_ack(spi_ack), .spi_idle(spi_idle), .grant_id(grant_id), .busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic stall_data = 1'b0;
  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  int ack_q[$];
  int exp_ack[$];

  int m_ptr = 0;
  bit m_valid = 0;
  logic [7:0] m_cfg = '0, m_div = '0;

  // spi_master responder: self-clearing ack, optional FIFO-full on data pushes.
  always @(negedge clk) begin
    if (!rst_n) spi_ack = 1'b0;
    else if (spi_req && !spi_ack && !(stall_data && spi_address == A_DATA)) begin
      spi_ack = 1'b1;
      wr_q.push_back({spi_address, spi_data});
    end else spi_ack = 1'b0;
  end

  function automatic int model_pick(logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  task automatic model_txn(int i);
    logic [7:0] c, d, x;
    c = cli_cfg[i*DW +: DW];
    d = cli_div[i*DW +: DW];
    x = cli_data[i*DW +: DW];
`ifdef SPI_ARB_CFG_CACHE_EN
    if (!m_valid || c != m_cfg) exp_q.push_back({A_CFG, c});
    if (!m_valid || d != m_div) exp_q.push_back({A_DIV, d});
    m_valid = 1;
    m_cfg = c;
    m_div = d;
`else
    exp_q.push_back({A_CFG, c});
    exp_q.push_back({A_DIV, d});
`endif
    exp_q.push_back({A_DATA, x});
    exp_ack.push_back(i);
    m_ptr = (i + 1) % N;
  endtask

  task automatic model_batch(logic [N-1:0] mask);
    logic [N-1:0] m;
    int i;
    m = mask;
    while (m != 0) begin
      i = model_pick(m);
      model_txn(i);
      m[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_valid = 0;
  endtask

  task automatic clear_q();
    wr_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack.delete();
  endtask

  task automatic set_client(int i, logic [7:0] c, logic [7:0] d, logic [7:0] x);
    cli_cfg[i*DW +: DW] = c;
    cli_div[i*DW +: DW] = d;
    cli_data[i*DW +: DW] = x;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cli_req = '0;
    stall_data = 1'b0;
    spi_idle = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_q();
  endtask

  // Gather cli_ack pulses, dropping each client's request right after its ack.
  task automatic collect(int n, int budget, output bit to);
    int got;
    int left;
    got = 0;
    left = budget;
    to = 0;
    while (got < n) begin
      @(negedge clk);
      left--;
      if (left < 0) begin
        to = 1;
        break;
      end
      for (int i = 0; i < N; i++) begin
        if (cli_ack[i]) begin
          ack_q.push_back(i);
          cli_req[i] = 1'b0;
          got++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({spi_req, spi_address, spi_data, cli_ack, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%0b addr=%0h data=%0h ack=%0b gid=%0d busy=%0b, want all 0",
               spi_req, spi_address, spi_data, cli_ack, grant_id, busy);
    end
    apply_reset();
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, spi_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b req=%0b, want 0 0", busy, spi_req);
    end
  endtask

  task automatic test_single();
    bit to;
    apply_reset();
    set_client(0, 8'h0A, 8'h02, 8'h5A);
    model_batch(4'b0001);
    cli_req = 4'b0001;
    collect(1, 100, to);
    repeat (3) @(negedge clk);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: timed_out=%0b want 0", to); end
    n_checks++;
    if (ack_q.size() !== 1 || wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL single_counts: acks=%0d writes=%0d, want 1 and %0d", ack_q.size(), wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      n_checks++;
      if (wr_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL single_write%0d: got %04h want %04h", k, wr_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_rr_tie();
    bit to;
    logic [N-1:0] masks[2];
    masks[0] = 4'b1010;
    masks[1] = 4'b0011;
    apply_reset();
    for (int i = 0; i < N; i++) set_client(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i));
    for (int r = 0; r < 2; r++) begin
      clear_q();
      model_batch(masks[r]);
      cli_req = masks[r];
      collect(2, 200, to);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL rr_timeout%0d: timed_out=%0b want 0", r, to); end
      for (int k = 0; k < exp_ack.size() && k < ack_q.size(); k++) begin
        n_checks++;
        if (ack_q[k] !== exp_ack[k]) begin
          n_fail++;
          $display("FAIL rr_order%0d_%0d: served %0d want %0d", r, k, ack_q[k], exp_ack[k]);
        end
      end
      n_checks++;
      if (wr_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rr_writes%0d: got %0d writes want %0d", r, wr_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_cache();
    bit to;
    clear_q();
    set_client(2, 8'h33, 8'h44, 8'h11);
    model_batch(4'b0100);
    cli_req = 4'b0100;
    collect(1, 100, to);
    set_client(2, 8'h33, 8'h44, 8'h22);
    model_batch(4'b0100);
`ifdef SPI_ARB_CFG_CACHE_EN
    spi_idle = 1'b0;
`endif
    cli_req = 4'b0100;
    collect(1, 100, to);
    spi_idle = 1'b1;
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL cache_timeout: timed_out=%0b want 0", to); end
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL cache_count: got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      n_checks++;
      if (wr_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL cache_write%0d: got %04h want %04h", k, wr_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_idle_wait();
    bit to;
    int bad;
    clear_q();
    set_client(1, 8'hC1, 8'hD1, 8'hE1);
    spi_idle = 1'b0;
    model_batch(4'b0010);
    cli_req = 4'b0010;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle_hold: spi_req high in %0d cycles, want 0", bad); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_busy: got %0b want 1", busy); end
    spi_idle = 1'b1;
    collect(1, 100, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: timed_out=%0b want 0", to); end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      n_checks++;
      if (wr_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL idle_write%0d: got %04h want %04h", k, wr_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_fifo_full();
    bit to;
    int wait_left;
    int bad;
    clear_q();
    set_client(3, 8'h7C, 8'h7D, 8'hA5);
    stall_data = 1'b1;
    model_batch(4'b1000);
    cli_req = 4'b1000;
    wait_left = 60;
    do begin
      @(negedge clk);
      wait_left--;
    end while (!(spi_req === 1'b1 && spi_address === A_DATA) && wait_left > 0);
    n_checks++;
    if (wait_left <= 0) begin n_fail++; $display("FAIL fifo_reach: WR_DATA not seen, addr=%0h req=%0b", spi_address, spi_req); end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (spi_req !== 1'b1 || spi_address !== A_DATA || spi_data !== 8'hA5 || cli_ack !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL fifo_hold: %0d cycles disturbed, want 0", bad); end
    stall_data = 1'b0;
    collect(1, 50, to);
    n_checks++;
    if (to !== 1'b0 || ack_q.size() !== 1) begin
      n_fail++;
      $display("FAIL fifo_ack: timed_out=%0b acks=%0d want 0 and 1", to, ack_q.size());
    end
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL fifo_writes: got %0d want %0d", wr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int wait_left;
    apply_reset();
    set_client(0, 8'h55, 8'h66, 8'h77);
    cli_req = 4'b0001;
    collect(1, 100, to);
    set_client(0, 8'h55, 8'h67, 8'h78);
    cli_req = 4'b0001;
    wait_left = 60;
    do begin
      @(negedge clk);
      wait_left--;
    end while (!(spi_req === 1'b1 && spi_address === A_DIV) && wait_left > 0);
    n_checks++;
    if (wait_left <= 0) begin n_fail++; $display("FAIL rstmid_reach: WR_DIV not seen"); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spi_req, spi_address, spi_data, cli_ack, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%0b addr=%0h data=%0h ack=%0b gid=%0d busy=%0b, want all 0",
               spi_req, spi_address, spi_data, cli_ack, grant_id, busy);
    end
    repeat (2) @(negedge clk);
    clear_q();
    model_reset();
    model_batch(4'b0001);
    rst_n = 1'b1;
    collect(1, 100, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: timed_out=%0b want 0", to); end
    n_checks++;
    if (wr_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d writes want %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      n_checks++;
      if (wr_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rstmid_write%0d: got %04h want %04h", k, wr_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [N-1:0] mask;
    int cnt;
    for (int b = 0; b < 8; b++) begin
      clear_q();
      for (int i = 0; i < N; i++)
        set_client(i, 8'h90 + 8'($urandom_range(0, 1)), 8'h04 + 8'($urandom_range(0, 1)), 8'($urandom));
      mask = N'($urandom_range(1, (1 << N) - 1));
      cnt = $countones(mask);
      model_batch(mask);
      cli_req = mask;
      collect(cnt, 60 * cnt, to);
      n_checks++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: timed_out=%0b want 0", b, to); end
      n_checks++;
      if (ack_q.size() !== exp_ack.size() || wr_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_counts: acks=%0d writes=%0d want %0d and %0d",
                 b, ack_q.size(), wr_q.size(), exp_ack.size(), exp_q.size());
      end
      for (int k = 0; k < exp_ack.size() && k < ack_q.size(); k++) begin
        n_checks++;
        if (ack_q[k] !== exp_ack[k]) begin
          n_fail++;
          $display("FAIL rand%0d_order%0d: served %0d want %0d", b, k, ack_q[k], exp_ack[k]);
        end
      end
      for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
        n_checks++;
        if (wr_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand%0d_write%0d: got %04h want %04h", b, k, wr_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_tie();
    test_cache();
    test_idle_wait();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
